// File: rtl/robo_sensor_conditioner.sv
// robo_sensor_conditioner
// -----------------------------------------------------------------------------
// Front end for the pipe-cleaning robot controller. It synchronises the four
// raw asynchronous sensor lines with two flops each and debounces the
// synchronised levels. It presents stable, clock-aligned levels, flags when
// those levels can be trusted after reset, pulses on every qualified change
// and keeps a saturating count of rejected bounces.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   raw_head/left/under/barrier   asynchronous raw sensor inputs
//   head/left/under/barrier       debounced levels, straight from flops
//   sensors_valid         high once the start-up settle period has elapsed
//   change_evt            one-cycle pulse after any debounced level changes
//   glitch_count          saturating count of aborted bounces (GLITCH_W bits)
//   dbg_state             settle FSM state (0 = S_FILL, 1 = S_RUN)
//
// Interface semantics: there is no handshake. Every output is a level or a
// pulse that is valid on every cycle and changes only on the rising clock edge.
//
// Optional feature, macro STICKY_UNDER_EN: when defined, the debounced under
// latches at 1 until reset. The end of the pipe is terminal for the
// controller. A later fall of raw_under is ignored. It counts no glitch and
// raises no change_evt.
// -----------------------------------------------------------------------------
module robo_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int GLITCH_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw_head,
  input  logic                raw_left,
  input  logic                raw_under,
  input  logic                raw_barrier,
  output logic                head,
  output logic                left,
  output logic                under,
  output logic                barrier,
  output logic                sensors_valid,
  output logic                change_evt,
  output logic [GLITCH_W-1:0] glitch_count,
  output logic                dbg_state
);

  typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_e;

  // Nine bits are enough for DEBOUNCE_CYCLES+1 up to 256.
  localparam int SETTLE_W = 9;
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DEBOUNCE_CYCLES + 1);

  // Sensor vector bit order: 0 head, 1 left, 2 under, 3 barrier.
  logic [3:0]          raw_vec;
  logic [3:0]          s1_q, s1_d, s2_q, s2_d;
  logic [3:0]          db_q, db_d;
  logic [3:0]          s2_eff;
  logic [CNT_W-1:0]    cnt_q [4];
  logic [CNT_W-1:0]    cnt_d [4];
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                change_q, change_d;
  logic                valid_q, valid_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  state_e              state_q, state_d;
  logic                any_abort;

  assign raw_vec = {raw_barrier, raw_under, raw_left, raw_head};

  always_comb begin
    s1_d      = raw_vec;
    s2_d      = s1_q;
    db_d      = db_q;
    glitch_d  = glitch_q;
    any_abort = 1'b0;
    s2_eff    = s2_q;
`ifdef STICKY_UNDER_EN
    // Once under has qualified high, it looks permanently "in agreement".
    // This freezes its counter at 0, so a fall can neither qualify nor abort.
    s2_eff[2] = s2_q[2] | db_q[2];
`else
    s2_eff[2] = s2_q[2];
`endif

    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_eff[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_eff[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (cnt_q[i] != '0) begin
        // The level went back before qualifying: this is a rejected bounce.
        any_abort = 1'b1;
      end
    end

    // Aborts on several sensors in one cycle count once. The count saturates.
    if (any_abort && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end

    change_d = |(db_d ^ db_q);

    // Settle FSM. The valid flag is registered from the state, so it rises
    // one edge after the state enters S_RUN.
    state_d  = state_q;
    settle_d = settle_q;
    valid_d  = (state_q == S_RUN);
    case (state_q)
      S_FILL: begin
        settle_d = settle_q + 1'b1;
        if (settle_d == SETTLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      glitch_q <= '0;
      change_q <= 1'b0;
      valid_q  <= 1'b0;
      settle_q <= '0;
      state_q  <= S_FILL;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      glitch_q <= glitch_d;
      change_q <= change_d;
      valid_q  <= valid_d;
      settle_q <= settle_d;
      state_q  <= state_d;
    end
  end

  assign head          = db_q[0];
  assign left          = db_q[1];
  assign under         = db_q[2];
  assign barrier       = db_q[3];
  assign sensors_valid = valid_q;
  assign change_evt    = change_q;
  assign glitch_count  = glitch_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/robo_sensor_conditioner.md
Name: robo_sensor_conditioner

Overview:
Upstream front end for the pipe-cleaning robot controller. It takes the four raw, asynchronous sensor lines (head, left, under, barrier) and synchronises each one. It then debounces them and presents stable, clock-aligned levels to the robot controller. It also reports when the outputs are trustworthy after reset, pulses on every qualified sensor change, and keeps a saturating glitch counter for diagnostics.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..255.
CNT_W, 8, width of each per-sensor debounce counter; must hold DEBOUNCE_CYCLES-1.
GLITCH_W, 8, width of glitch_count.

Ports:
clock  input  1  single system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
raw_head  input  1  raw head sensor, asynchronous.
raw_left  input  1  raw left-wall sensor, asynchronous.
raw_under  input  1  raw under (end-of-pipe) sensor, asynchronous.
raw_barrier  input  1  raw barrier/trash sensor, asynchronous.
head  output  1  debounced head, feeds the controller.
left  output  1  debounced left.
under  output  1  debounced under.
barrier  output  1  debounced barrier.
sensors_valid  output  1  high once the start-up settle period is complete.
change_evt  output  1  one-cycle pulse when any debounced output changes.
glitch_count  output  GLITCH_W  saturating count of rejected bounces.

Behaviour:
- Reset (clock edge with reset=1):
  - All synchronisers, debounce counters and debounced outputs go to 0.
  - sensors_valid, change_evt and glitch_count go to 0.
  - FSM goes to S_FILL.
  - Reset has priority over all other activity. Reset mid-debounce discards the partial count.
- Synchroniser: two flops per raw input (s1, s2). Only s2 is used downstream.
- Debouncer, per sensor, with output register q and counter c:
  - s2==q: c<=0.
  - s2!=q and c==DEBOUNCE_CYCLES-1: q<=s2, c<=0.
  - s2!=q otherwise: c<=c+1.
- Latency: a raw level held stable appears on the output at rising edge DEBOUNCE_CYCLES+2 after the edge that first samples it. With the default of 4, that is edge 6.
- Glitch: s2==q while c!=0 (a bounce aborted before qualifying) increments glitch_count by 1. It saturates at all-ones and never wraps. Aborts on several sensors in the same cycle count as 1.
- change_evt: registered. It is high in the cycle after any q update, for exactly one cycle even if several sensors change together. Back-to-back qualifications produce back-to-back pulses.
- FSM with 2 states:
  - S_FILL: sensors_valid=0. A settle counter runs from 0. The state moves to S_RUN on the edge where the count reaches DEBOUNCE_CYCLES+1, so sensors_valid rises at edge DEBOUNCE_CYCLES+2 after reset deasserts.
  - S_RUN: sensors_valid=1. The block stays here until reset.
  - Debouncing, change_evt and glitch counting operate in both states.
- Outputs head/left/under/barrier are driven directly from q registers, with no combinational path from raw inputs.
- Edge case: an input toggling every cycle never qualifies. Its q holds and glitch_count increments on each abort.

Optional Feature:
STICKY_UNDER_EN:
- Defined: once the debounced under becomes 1 it stays 1 until reset, because the end of the pipe is terminal for the controller. A raw under returning to 0 is ignored and counts no glitch, and no change_evt is raised for that fall.
- Undefined: under is debounced exactly like the other sensors.

Test Plan:
- Reset 3 cycles, all raw=0 -> all outputs 0, sensors_valid rises at edge 6 after reset release, glitch_count=0.
- DEBOUNCE_CYCLES=4, raw_head 0->1 held -> head=1 at edge 6 after first sample; change_evt high for exactly 1 cycle after; other outputs unchanged.
- raw_barrier pulsed high for 2 cycles then low -> barrier stays 0, glitch_count increments 0->1, no change_evt.
- raw_left and raw_barrier rise in the same cycle -> both outputs rise on the same edge, single change_evt pulse; then raw_left toggles every cycle for 20 cycles -> left holds 1 and glitch_count increases monotonically (forcing 300 aborts saturates it at 255).
- raw_under high for 10 cycles then low: with STICKY_UNDER_EN under stays 1 until reset; without it under returns to 0 six edges after the fall.
- Assert reset while raw_head has been high for 3 cycles (mid-count) -> head=0, counter cleared; after release head qualifies only after a full 6 edges.
